// File: rtl/multicycle_ctrl.sv
// Multicycle RV32I-subset controller: sequences a shared-memory datapath over 3-5+ cycles per instruction.
// Outputs decode the registered state (plus opcode/funct3, BranchCond, mem_ready); state advances each clk edge.
// Memory accesses hold mem_req/MemWrite/AdrSrc steady until mem_ready; an undecoded opcode parks the FSM in TRAP.
module multicycle_ctrl #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] instr,
  input  logic                  BranchCond,
  input  logic                  mem_ready,
  output logic                  mem_req,
  output logic                  MemWrite,
  output logic                  AdrSrc,
  output logic                  IRWrite,
  output logic                  PCWrite,
  output logic [1:0]            PCSrc,
  output logic                  RegWrite,
  output logic [1:0]            ResultSrc,
  output logic                  ALUsrc,
  output logic [2:0]            ALUctrl,
  output logic [1:0]            ImmSrc,
  output logic                  halted,
  output logic [DATA_WIDTH-1:0] retired
);

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
    S_EXECI, S_ALUWB, S_BRANCH, S_JAL, S_JALR, S_TRAP
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  state_t                state;
  state_t                decode_next;
  logic [DATA_WIDTH-1:0] retired_cnt;
  logic                  retire;
  logic [6:0]            opcode;
  logic [2:0]            funct3;
  logic                  unused_instr_bits;

  assign opcode            = instr[6:0];
  assign funct3            = instr[14:12];
  assign unused_instr_bits = ^{instr[DATA_WIDTH-1:15], instr[11:7]};
  assign retired           = retired_cnt;

  // Instruction classification used when leaving DECODE; anything unrecognised traps.
  always_comb begin
    decode_next = S_TRAP;
    unique case (opcode)
      OP_LOAD, OP_STORE: decode_next = S_MEMADR;
      OP_IMM:    if (funct3 == 3'b000 || funct3 == 3'b010 ||
                     funct3 == 3'b110 || funct3 == 3'b111) decode_next = S_EXECI;
      OP_BRANCH: if (funct3 != 3'b010 && funct3 != 3'b011) decode_next = S_BRANCH;
      OP_JAL:    decode_next = S_JAL;
      OP_JALR:   if (funct3 == 3'b000) decode_next = S_JALR;
      default:   decode_next = S_TRAP;
    endcase
  end

  // Final cycle of every instruction bumps the retired counter; a stalled store waits for mem_ready.
  assign retire = (state == S_MEMWB) || (state == S_ALUWB) || (state == S_BRANCH) ||
                  (state == S_JAL)   || (state == S_JALR)  ||
                  ((state == S_MEMWRITE) && mem_ready);

  // State sequencing and retired-instruction counter.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= S_FETCH;
      retired_cnt <= '0;
    end else begin
      if (retire) retired_cnt <= retired_cnt + {{(DATA_WIDTH-1){1'b0}}, 1'b1};
      case (state)
        S_FETCH:    if (mem_ready) state <= S_DECODE;
        S_DECODE:   state <= decode_next;
        S_MEMADR:   state <= (opcode == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
        S_MEMREAD:  if (mem_ready) state <= S_MEMWB;
        S_MEMWRITE: if (mem_ready) state <= S_FETCH;
        S_EXECI:    state <= S_ALUWB;
        S_TRAP:     state <= S_TRAP;
        default:    state <= S_FETCH;
      endcase
    end
  end

  // Datapath controls per state; everything idles while reset is held.
  always_comb begin
    mem_req   = 1'b0;
    MemWrite  = 1'b0;
    AdrSrc    = 1'b0;
    IRWrite   = 1'b0;
    PCWrite   = 1'b0;
    PCSrc     = 2'b00;
    RegWrite  = 1'b0;
    ResultSrc = 2'b00;
    ALUsrc    = 1'b0;
    ALUctrl   = 3'b111;
    ImmSrc    = 2'b00;
    halted    = 1'b0;
    if (rst) begin
      case (state)
        S_FETCH: begin
          mem_req = 1'b1;
          IRWrite = mem_ready;
          PCWrite = mem_ready;
        end
        S_DECODE: begin
          case (opcode)
            OP_STORE:  ImmSrc = 2'b01;
            OP_BRANCH: ImmSrc = 2'b10;
            OP_JAL:    ImmSrc = 2'b11;
            default:   ImmSrc = 2'b00;
          endcase
        end
        S_MEMADR: begin
          ALUsrc  = 1'b1;
          ALUctrl = 3'b000;
          ImmSrc  = (opcode == OP_STORE) ? 2'b01 : 2'b00;
        end
        S_MEMREAD: begin
          mem_req = 1'b1;
          AdrSrc  = 1'b1;
        end
        S_MEMWB: begin
          RegWrite  = 1'b1;
          ResultSrc = 2'b01;
        end
        S_MEMWRITE: begin
          mem_req  = 1'b1;
          MemWrite = 1'b1;
          AdrSrc   = 1'b1;
        end
        S_EXECI: begin
          ALUsrc = 1'b1;
          case (funct3)
            3'b010:  ALUctrl = 3'b101;
            3'b110:  ALUctrl = 3'b011;
            3'b111:  ALUctrl = 3'b010;
            default: ALUctrl = 3'b000;
          endcase
        end
        S_ALUWB: RegWrite = 1'b1;
        S_BRANCH: begin
          case (funct3)
            3'b001:         ALUctrl = 3'b001;
            3'b100, 3'b110: ALUctrl = 3'b010;
            3'b101, 3'b111: ALUctrl = 3'b011;
            default:        ALUctrl = 3'b000;
          endcase
          ImmSrc  = 2'b10;
          PCSrc   = 2'b01;
          PCWrite = BranchCond;
        end
        S_JAL: begin
          ImmSrc    = 2'b11;
          PCSrc     = 2'b01;
          PCWrite   = 1'b1;
          RegWrite  = 1'b1;
          ResultSrc = 2'b10;
        end
        S_JALR: begin
          ALUsrc    = 1'b1;
          ALUctrl   = 3'b000;
          PCSrc     = 2'b10;
          PCWrite   = 1'b1;
          RegWrite  = 1'b1;
          ResultSrc = 2'b10;
        end
        S_TRAP:  halted = 1'b1;
        default: halted = 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed, table-driven check of multicycle_ctrl: every cycle compares all controls and retired count.
module tb_multicycle_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] instr;
  logic        BranchCond;
  logic        mem_ready;
  logic        mem_req, MemWrite, AdrSrc, IRWrite, PCWrite, RegWrite, ALUsrc, halted;
  logic [1:0]  PCSrc, ResultSrc, ImmSrc;
  logic [2:0]  ALUctrl;
  logic [31:0] retired;

  multicycle_ctrl #(.DATA_WIDTH(32)) dut (
    .clk(clk), .rst(rst), .instr(instr), .BranchCond(BranchCond), .mem_ready(mem_ready),
    .mem_req(mem_req), .MemWrite(MemWrite), .AdrSrc(AdrSrc), .IRWrite(IRWrite),
    .PCWrite(PCWrite), .PCSrc(PCSrc), .RegWrite(RegWrite), .ResultSrc(ResultSrc),
    .ALUsrc(ALUsrc), .ALUctrl(ALUctrl), .ImmSrc(ImmSrc), .halted(halted), .retired(retired)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       req, mw, adr, irw, pcw;
    logic [1:0] pcsrc;
    logic       rw;
    logic [1:0] rsrc;
    logic       asrc;
    logic [2:0] actl;
    logic [1:0] imm;
    logic       halt;
  } ctl_t;

  typedef struct {
    logic        rst;
    logic [31:0] instr;
    logic        bc;
    logic        rdy;
    ctl_t        exp;
    logic [31:0] ret;
  } vec_t;

  vec_t vq[$];
  int   nvec = 0;
  int   nerr = 0;

  function automatic ctl_t mk(input logic req, mw, adr, irw, pcw, input logic [1:0] pcsrc,
                              input logic rw, input logic [1:0] rsrc, input logic asrc,
                              input logic [2:0] actl, input logic [1:0] imm, input logic halt);
    return {req, mw, adr, irw, pcw, pcsrc, rw, rsrc, asrc, actl, imm, halt};
  endfunction

  // Hand-written expected control words per state
  ctl_t IDLE, FW, FR, DEC00, DEC01, DEC10, DEC11, MADR_LW, MADR_SW, MRD, MWB, MWR;
  ctl_t EX000, EX101, EX010, EX011, AWB, BR000_T, BR001_N, BR011_T, BR010_N, JAL, JALR, TRAP;

  task automatic add(input logic r, input logic [31:0] i, input logic b, input logic m,
                     input ctl_t e, input logic [31:0] ret);
    vec_t v;
    v.rst = r; v.instr = i; v.bc = b; v.rdy = m; v.exp = e; v.ret = ret;
    vq.push_back(v);
  endtask

  // One cycle: drive at negedge, compare mid-cycle, then let the posedge happen.
  task automatic step(input logic r, input logic [31:0] i, input logic b, input logic m,
                      input ctl_t e, input logic [31:0] ret, input string name, input logic do_force);
    ctl_t act;
    @(negedge clk);
    rst = r; instr = i; BranchCond = b; mem_ready = m;
    if (do_force) begin
      force dut.retired_cnt = 32'hFFFF_FFFF;
      #1;
      release dut.retired_cnt;
    end
    #1;
    act = {mem_req, MemWrite, AdrSrc, IRWrite, PCWrite, PCSrc, RegWrite, ResultSrc,
           ALUsrc, ALUctrl, ImmSrc, halted};
    nvec++;
    if (act !== e) begin
      nerr++;
      $display("FAIL %s ctl: got %h want %h", name, act, e);
    end
    nvec++;
    if (retired !== ret) begin
      nerr++;
      $display("FAIL %s retired: got %h want %h", name, retired, ret);
    end
  endtask

  localparam logic [31:0] ADDI = 32'h0050_0093, LW   = 32'h0000_A103, SLTI = 32'h0000_2013;
  localparam logic [31:0] ANDI = 32'h0000_7013, ORI  = 32'h0000_6013, BEQ  = 32'h0000_0063;
  localparam logic [31:0] BNE  = 32'h0000_1063, BGEU = 32'h0000_7063, BLT  = 32'h0000_4063;
  localparam logic [31:0] JALI = 32'h0000_006F, JALRI = 32'h0000_0067, ILL = 32'h0000_007F;
  localparam logic [31:0] SW   = 32'h0020_A023;

  initial begin
    //         req mw adr irw pcw pcsrc rw rsrc  asrc actl    imm   halt
    IDLE    = mk(0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 0, 3'b111, 2'b00, 0);
    FW      = mk(1, 0, 0, 0, 0, 2'b00, 0, 2'b00, 0, 3'b111, 2'b00, 0);
    FR      = mk(1, 0, 0, 1, 1, 2'b00, 0, 2'b00, 0, 3'b111, 2'b00, 0);
    DEC00   = mk(0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 0, 3'b111, 2'b00, 0);
    DEC01   = mk(0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 0, 3'b111, 2'b01, 0);
    DEC10   = mk(0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 0, 3'b111, 2'b10, 0);
    DEC11   = mk(0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 0, 3'b111, 2'b11, 0);
    MADR_LW = mk(0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 1, 3'b000, 2'b00, 0);
    MADR_SW = mk(0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 1, 3'b000, 2'b01, 0);
    MRD     = mk(1, 0, 1, 0, 0, 2'b00, 0, 2'b00, 0, 3'b111, 2'b00, 0);
    MWB     = mk(0, 0, 0, 0, 0, 2'b00, 1, 2'b01, 0, 3'b111, 2'b00, 0);
    MWR     = mk(1, 1, 1, 0, 0, 2'b00, 0, 2'b00, 0, 3'b111, 2'b00, 0);
    EX000   = mk(0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 1, 3'b000, 2'b00, 0);
    EX101   = mk(0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 1, 3'b101, 2'b00, 0);
    EX010   = mk(0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 1, 3'b010, 2'b00, 0);
    EX011   = mk(0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 1, 3'b011, 2'b00, 0);
    AWB     = mk(0, 0, 0, 0, 0, 2'b00, 1, 2'b00, 0, 3'b111, 2'b00, 0);
    BR000_T = mk(0, 0, 0, 0, 1, 2'b01, 0, 2'b00, 0, 3'b000, 2'b10, 0);
    BR001_N = mk(0, 0, 0, 0, 0, 2'b01, 0, 2'b00, 0, 3'b001, 2'b10, 0);
    BR011_T = mk(0, 0, 0, 0, 1, 2'b01, 0, 2'b00, 0, 3'b011, 2'b10, 0);
    BR010_N = mk(0, 0, 0, 0, 0, 2'b01, 0, 2'b00, 0, 3'b010, 2'b10, 0);
    JAL     = mk(0, 0, 0, 0, 1, 2'b01, 1, 2'b10, 0, 3'b111, 2'b11, 0);
    JALR    = mk(0, 0, 0, 0, 1, 2'b10, 1, 2'b10, 1, 3'b000, 2'b00, 0);
    TRAP    = mk(0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 0, 3'b111, 2'b00, 1);

    // addi, zero wait: 4 cycles
    add(1, ADDI, 0, 1, FR, 0);     add(1, ADDI, 0, 1, DEC00, 0);
    add(1, ADDI, 0, 1, EX000, 0);  add(1, ADDI, 0, 1, AWB, 0);
    // lw with 2 wait states on fetch and on read: 9 cycles
    add(1, LW, 0, 0, FW, 1);       add(1, LW, 0, 0, FW, 1);       add(1, LW, 0, 1, FR, 1);
    add(1, LW, 0, 1, DEC00, 1);    add(1, LW, 0, 1, MADR_LW, 1);
    add(1, LW, 0, 0, MRD, 1);      add(1, LW, 0, 0, MRD, 1);      add(1, LW, 0, 1, MRD, 1);
    add(1, LW, 0, 1, MWB, 1);
    // slti / andi / ori ALU-control mapping
    add(1, SLTI, 0, 1, FR, 2);     add(1, SLTI, 0, 1, DEC00, 2);
    add(1, SLTI, 0, 1, EX101, 2);  add(1, SLTI, 0, 1, AWB, 2);
    add(1, ANDI, 0, 1, FR, 3);     add(1, ANDI, 0, 1, DEC00, 3);
    add(1, ANDI, 0, 1, EX010, 3);  add(1, ANDI, 0, 1, AWB, 3);
    add(1, ORI, 0, 1, FR, 4);      add(1, ORI, 0, 1, DEC00, 4);
    add(1, ORI, 0, 1, EX011, 4);   add(1, ORI, 0, 1, AWB, 4);
    // branches: taken beq, not-taken bne (BranchCond ignored in DECODE), taken bgeu, not-taken blt
    add(1, BEQ, 1, 1, FR, 5);      add(1, BEQ, 1, 1, DEC10, 5);   add(1, BEQ, 1, 1, BR000_T, 5);
    add(1, BNE, 1, 1, FR, 6);      add(1, BNE, 1, 1, DEC10, 6);   add(1, BNE, 0, 1, BR001_N, 6);
    add(1, BGEU, 1, 1, FR, 7);     add(1, BGEU, 1, 1, DEC10, 7);  add(1, BGEU, 1, 1, BR011_T, 7);
    add(1, BLT, 0, 1, FR, 8);      add(1, BLT, 0, 1, DEC10, 8);   add(1, BLT, 0, 1, BR010_N, 8);
    // jal then jalr: 6 cycles, +2 retired
    add(1, JALI, 0, 1, FR, 9);     add(1, JALI, 0, 1, DEC11, 9);  add(1, JALI, 0, 1, JAL, 9);
    add(1, JALRI, 0, 1, FR, 10);   add(1, JALRI, 0, 1, DEC00, 10); add(1, JALRI, 0, 1, JALR, 10);
    // illegal opcode: TRAP is sticky, no memory requests even with mem_ready high
    add(1, ILL, 0, 1, FR, 11);     add(1, ILL, 0, 1, DEC00, 11);
    for (int k = 0; k < 20; k++) add(1, ILL, 0, 1, TRAP, 11);
    // one reset cycle: idle while low, then FETCH with retired cleared
    add(0, ILL, 0, 1, IDLE, 11);
    add(1, ILL, 0, 0, FW, 0);

    rst = 1'b0; instr = '0; BranchCond = 1'b0; mem_ready = 1'b0;
    @(posedge clk);
    step(0, ADDI, 0, 1, IDLE, 0, "reset_hold", 0);

    for (int n = 0; n < vq.size(); n++)
      step(vq[n].rst, vq[n].instr, vq[n].bc, vq[n].rdy, vq[n].exp, vq[n].ret,
           $sformatf("vec%0d", n), 0);

    // sw with counter preloaded to all-ones and one write wait state: wraps to 0
    step(1, SW, 0, 1, FR, 32'hFFFF_FFFF, "sw_fetch", 1);
    step(1, SW, 0, 1, DEC01, 32'hFFFF_FFFF, "sw_decode", 0);
    step(1, SW, 0, 1, MADR_SW, 32'hFFFF_FFFF, "sw_memadr", 0);
    step(1, SW, 0, 0, MWR, 32'hFFFF_FFFF, "sw_wait", 0);
    step(1, SW, 0, 1, MWR, 32'hFFFF_FFFF, "sw_write", 0);
    // lw aborted by reset mid-read: mem_req drops, FETCH resumes
    step(1, LW, 0, 1, FR, 0, "abort_fetch", 0);
    step(1, LW, 0, 1, DEC00, 0, "abort_decode", 0);
    step(1, LW, 0, 1, MADR_LW, 0, "abort_memadr", 0);
    step(1, LW, 0, 0, MRD, 0, "abort_read", 0);
    step(0, LW, 0, 0, IDLE, 0, "abort_rst", 0);
    step(1, LW, 0, 0, FW, 0, "abort_refetch", 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Finite-state controller that sequences a shared-memory multicycle datapath for the RV32I subset handled by the single-cycle decoder: lw, sw, addi/slti/ori/andi, beq/bne/blt/bge/bltu/bgeu, jal and jalr. It sits beside the register file, ALU and a single unified instruction/data memory port. On each step it drives the datapath enables and the mux selects, and it handshakes every memory access. It also counts retired instructions and halts on any undecoded opcode.

## Interface
- DATA_WIDTH, 32, instruction and counter width
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  synchronous, active-low reset
- instr  in  DATA_WIDTH  instruction register contents (valid from DECODE onward)
- BranchCond  in  1  ALU comparison result for the current branch (1 = taken)
- mem_ready  in  1  memory completes the pending access this cycle
- mem_req  out  1  memory access request
- MemWrite  out  1  access is a write (qualifies mem_req)
- AdrSrc  out  1  memory address: 0 = PC, 1 = ALU result register
- IRWrite  out  1  load instr and OldPC registers
- PCWrite  out  1  load PC
- PCSrc  out  2  00 = PC+4, 01 = OldPC+imm, 10 = ALU result with bit 0 cleared
- RegWrite  out  1  register file write
- ResultSrc  out  2  00 = ALU result, 01 = memory data, 10 = OldPC+4
- ALUsrc  out  1  ALU operand B: 0 = rs2, 1 = immediate
- ALUctrl  out  3  000 add, 001 ne-compare, 010 and/lt, 011 or/ge, 101 slt, 111 idle
- ImmSrc  out  2  00 I-type, 01 S-type, 10 B-type, 11 J-type
- halted  out  1  controller is in TRAP
- retired  out  DATA_WIDTH  retired-instruction count; wraps from all-ones to 0

## Operation
- States: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECI, ALUWB, BRANCH, JAL, JALR, TRAP. All outputs are a function of the registered state and instr (Moore plus opcode decode).
- FETCH: mem_req=1, AdrSrc=0. On mem_ready: IRWrite=1, PCWrite=1, PCSrc=00, then go to DECODE. Otherwise stay.
- DECODE: ImmSrc is set from the opcode; no enables. Next state by opcode:
  - 0000011 → MEMADR
  - 0100011 → MEMADR
  - 0010011 with funct3 in {000, 010, 110, 111} → EXECI
  - 1100011 with funct3 not 010/011 → BRANCH
  - 1101111 → JAL
  - 1100111 with funct3 000 → JALR
  - anything else → TRAP
- MEMADR: ALUsrc=1, ALUctrl=000, ImmSrc=00 (lw) or 01 (sw). Go to MEMREAD for lw, MEMWRITE for sw.
- MEMREAD: mem_req=1, AdrSrc=1, MemWrite=0. Hold until mem_ready, then go to MEMWB.
- MEMWB: RegWrite=1, ResultSrc=01, then go to FETCH.
- MEMWRITE: mem_req=1, MemWrite=1, AdrSrc=1. Hold until mem_ready, then go to FETCH.
- EXECI: ALUsrc=1, with ALUctrl from funct3: 000→000, 010→101, 110→011, 111→010. Then go to ALUWB.
- ALUWB: RegWrite=1, ResultSrc=00, then go to FETCH.
- BRANCH: ALUsrc=0, with ALUctrl from funct3: 000→000, 001→001, 100/110→010, 101/111→011. ImmSrc=10, PCSrc=01, PCWrite=BranchCond. Then go to FETCH.
- JAL: ImmSrc=11, PCSrc=01, PCWrite=1, RegWrite=1, ResultSrc=10. Then go to FETCH.
- JALR: ALUsrc=1, ALUctrl=000, PCSrc=10, PCWrite=1, RegWrite=1, ResultSrc=10. Then go to FETCH.
- TRAP: every enable and mem_req is 0, halted=1. The state is sticky until reset.
- retired increments by 1 on the final cycle of each instruction:
  - MEMWB
  - MEMWRITE when mem_ready=1
  - ALUWB, BRANCH, JAL, JALR
- retired never increments on TRAP entry.
- Idle defaults for all states: every enable 0, ALUctrl=111, ImmSrc=00, PCSrc=00, ResultSrc=00, ALUsrc=0, AdrSrc=0.

## Timing
- Reset (rst=0 at an edge) forces the next state to FETCH and retired to 0.
- In the cycle following a reset edge, outputs are those of FETCH. Idle defaults apply during cycles with rst low.
- Reset mid-access aborts the transfer. mem_req may fall without mem_ready only because of reset.
- mem_req, MemWrite and AdrSrc stay constant from assertion until the mem_ready cycle inclusive. mem_ready is ignored while mem_req=0.
- Zero-wait-state cycle counts:
  - ALU-immediate 4
  - lw 5
  - sw 4
  - branch 3
  - jal 3
  - jalr 3
- Each wait state on a memory access adds exactly 1 cycle.
- A write-enable pulse (RegWrite, PCWrite, IRWrite) lasts exactly 1 cycle per instruction, except FETCH's PCWrite/IRWrite, which coincide with mem_ready.
- The retired counter updates at the edge that ends the instruction's final cycle. Wrap-around is silent.

## Test plan
- Reset, then addi (0x00500093) with mem_ready tied high. Required: states FETCH→DECODE→EXECI→ALUWB; RegWrite high only in cycle 4; retired=1 after 4 cycles.
- lw (0x0000A103) with mem_ready low for 2 cycles in both FETCH and MEMREAD. Required: mem_req held steady throughout; 9 cycles total; ResultSrc=01 at MEMWB.
- beq with BranchCond=1, then bne with BranchCond=0. Required: PCWrite=1/PCSrc=01 in the first BRANCH state, PCWrite=0 in the second; ALUctrl 000 then 001.
- jal followed by jalr. Required: JAL drives PCSrc=01, ResultSrc=10, RegWrite=1; JALR drives PCSrc=10, ALUsrc=1; retired=2 after 6 cycles.
- Illegal opcode 0x0000007F. Required: TRAP after DECODE; halted=1; mem_req stays 0 for 20 cycles; retired unchanged. Then rst=0 for 1 cycle: returns to FETCH with halted=0.
- Preload retired to 0xFFFFFFFF (force), then sw (0x0020A023). Required: MemWrite=1 with AdrSrc=1 in MEMWRITE; retired wraps to 0.
